mpe_tile_feeder: RTL and testbench
==================================

Name: mpe_tile_feeder

Overview:
- Transmit side of the MPE operand interface.
- Accepts a tile descriptor (beat count, mode, scale, bias) and a ready/valid stream of K-chunks of matrices A and B.
- Drives the MPE operand ports one chunk per cycle and asserts the "inputs complete" strobe the cycle after the last chunk.
- Waits for the MPE result strobe before the next tile, so accumulator clear never overlaps new data.

Parameters:
DIMM1, 2, rows of A / output rows (row 0 is the 8-bit row, rows 1..DIMM1-1 are 4-bit).
DIMM2, 1, columns of B / output columns.
DIMM3, 64, reduction length per beat.
BEAT_W, 8, width of tile beat count; max tile = 2^BEAT_W-1 beats.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tile_start  in  1  descriptor strobe, sampled only in IDLE
tile_beats  in  BEAT_W  number of K-beats in tile
tile_mode  in  2  precision mode for the tile
tile_scale  in  DIMM1*DIMM2*32  per-element scale pair
tile_bias  in  DIMM1*DIMM2*16  per-element fp16 bias
tile_busy  out  1  state != IDLE
tile_done  out  1  one-cycle pulse, tile result delivered
s_valid  in  1  operand beat valid
s_ready  out  1  operand beat ready
s_a_first  in  DIMM3*8  A row 0, int8 per k
s_a_rest  in  DIMM3*(DIMM1-1)*4  A rows 1.., int4
s_b  in  DIMM3*DIMM2*4  B, int4
mpe_mode  out  2  registered tile_mode
mpe_a_first / mpe_a_rest / mpe_b  out  widths as s_*  operand drive
mpe_scale  out  DIMM1*DIMM2*32  registered scale, held for whole tile
mpe_bias  out  DIMM1*DIMM2*16  bias, non-zero only on first beat
mpe_in_valid  out  1  inputs-complete strobe
mpe_out_valid  in  1  MPE result-valid strobe

Behaviour:
- Reset (async, any time including mid-tile): state IDLE; all outputs 0; beat counter 0; in-flight tile discarded, no tile_done.
- States: IDLE, STREAM, FLAG, WAIT, GAP.
- IDLE:
  - tile_start with tile_beats != 0: latch beats, mode, scale, bias; go STREAM next cycle.
  - tile_beats == 0: start ignored, stay IDLE, no done.
  - tile_start in any other state is ignored.
- STREAM:
  - s_ready = 1 (combinational from state only).
  - Each handshake (s_valid & s_ready) registers the beat onto mpe_a_first/rest/b the next cycle and increments the counter.
  - Bubble cycle (no handshake): next cycle mpe A/B/bias driven all-zero, so the MPE adds zero.
  - mpe_bias = latched bias only on the cycle carrying beat 0; zero otherwise.
  - Handshake on the beat where counter+1 == tile_beats: go FLAG.
- FLAG (one cycle): s_ready = 0; mpe ports carry the last beat.
- Entering WAIT: mpe_in_valid = 1 for exactly one cycle; mpe A/B/bias = 0.
- WAIT: hold zeros, s_ready = 0, mpe_mode/mpe_scale held. On mpe_out_valid: tile_done = 1 next cycle, go GAP.
- GAP (one cycle, covers MPE accumulator clear): then IDLE. tile_done is asserted during the GAP cycle.
- Timing: last handshake at cycle N → last beat on mpe ports N+1 → mpe_in_valid N+2.
- mpe_out_valid outside WAIT is ignored.
- mpe_mode and mpe_scale update only at tile start.
- Counter width BEAT_W, no wrap (terminal compare).

Optional Feature:
MPE_TILE_FEEDER_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0]. Counts STREAM cycles with s_valid = 0. Cleared on tile start (IDLE→STREAM); saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- tile_beats=4, s_valid held 1, beats A0..A3 → mpe ports show A0..A3 on 4 consecutive cycles; bias only with A0; mpe_in_valid 2 cycles after A3 handshake; mpe_out_valid 2 cycles later → tile_done 1 cycle after, busy low next cycle.
- tile_beats=3 with s_valid low for 2 cycles between beat 1 and 2 → two all-zero cycles on mpe ports; mpe_in_valid still after beat 2; stall_cnt=2 when macro defined.
- tile_beats=1 → single beat carries bias; FLAG then mpe_in_valid; s_ready high for exactly 1 cycle.
- tile_beats=0 with tile_start; tile_start pulsed in WAIT → no state change, no done, no s_ready.
- rst_n low mid-STREAM after 2 of 4 beats → all outputs 0 asynchronously; after release IDLE; a new 2-beat tile completes normally.
- mpe_out_valid pulsed in STREAM → ignored; done only after the WAIT-phase strobe.

Source files
------------

// File: rtl/mpe_tile_feeder.sv
// mpe_tile_feeder: transmit side of the MPE operand interface.
//
// Accepts a tile descriptor (beat count, precision mode, scale, bias) and a
// ready/valid stream of K-chunks of A and B, and presents them on the MPE
// operand ports one chunk per cycle. After the last chunk it raises the
// "inputs complete" strobe. It then waits for the MPE result strobe and
// spends one extra cycle while the MPE clears its accumulators. Only after
// that does it accept the next tile, so an accumulator clear never overlaps
// new data.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   tile_start       descriptor strobe (sampled only when idle)
//   tile_beats       K-beats in the tile (0 = start ignored)
//   tile_mode        precision mode for the tile
//   tile_scale       per-element scale pair, DIMM1*DIMM2*32 bits
//   tile_bias        per-element fp16 bias, DIMM1*DIMM2*16 bits
//   tile_busy        high whenever a tile is in flight
//   tile_done        one-cycle pulse, tile result delivered
//   s_valid/s_ready  operand stream handshake
//   s_a_first        A row 0, int8 per k
//   s_a_rest         A rows 1..DIMM1-1, int4 per k
//   s_b              B, int4 per k
//   mpe_mode         registered tile mode
//   mpe_a_first, mpe_a_rest, mpe_b   registered operand drive
//   mpe_scale        registered scale, held for the whole tile
//   mpe_bias         bias, non-zero only on the cycle carrying beat 0
//   mpe_in_valid     inputs-complete strobe
//   mpe_out_valid    MPE result-valid strobe
//
// Optional feature, macro MPE_TILE_FEEDER_STALL_CNT_EN:
//   adds output stall_cnt[15:0]. It counts streaming cycles with s_valid low,
//   clears at tile start and saturates at 16'hFFFF.

module mpe_tile_feeder #(
  parameter int DIMM1  = 2,
  parameter int DIMM2  = 1,
  parameter int DIMM3  = 64,
  parameter int BEAT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tile_start,
  input  logic [BEAT_W-1:0]             tile_beats,
  input  logic [1:0]                    tile_mode,
  input  logic [DIMM1*DIMM2*32-1:0]     tile_scale,
  input  logic [DIMM1*DIMM2*16-1:0]     tile_bias,
  output logic                          tile_busy,
  output logic                          tile_done,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIMM3*8-1:0]            s_a_first,
  input  logic [DIMM3*(DIMM1-1)*4-1:0]  s_a_rest,
  input  logic [DIMM3*DIMM2*4-1:0]      s_b,
  output logic [1:0]                    mpe_mode,
  output logic [DIMM3*8-1:0]            mpe_a_first,
  output logic [DIMM3*(DIMM1-1)*4-1:0]  mpe_a_rest,
  output logic [DIMM3*DIMM2*4-1:0]      mpe_b,
  output logic [DIMM1*DIMM2*32-1:0]     mpe_scale,
  output logic [DIMM1*DIMM2*16-1:0]     mpe_bias,
  output logic                          mpe_in_valid,
  input  logic                          mpe_out_valid
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int A_FIRST_W = DIMM3 * 8;
  localparam int A_REST_W  = DIMM3 * (DIMM1 - 1) * 4;
  localparam int B_W       = DIMM3 * DIMM2 * 4;
  localparam int SCALE_W   = DIMM1 * DIMM2 * 32;
  localparam int BIAS_W    = DIMM1 * DIMM2 * 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLAG,
    ST_WAIT,
    ST_GAP
  } state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [SCALE_W-1:0]    scale_q, scale_d;
  logic [BIAS_W-1:0]     bias_lat_q, bias_lat_d;
  logic [A_FIRST_W-1:0]  a_first_q, a_first_d;
  logic [A_REST_W-1:0]   a_rest_q, a_rest_d;
  logic [B_W-1:0]        b_q, b_d;
  logic [BIAS_W-1:0]     bias_q, bias_d;
  logic                  in_valid_q, in_valid_d;
  logic                  done_q, done_d;
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
  logic [15:0]           stall_q, stall_d;
`endif

  logic                  handshake;
  logic                  last_beat;

  // Ready depends on state alone, so the upstream never sees a path from its
  // own valid back into ready.
  assign s_ready   = (state_q == ST_STREAM);
  assign handshake = s_valid && s_ready;

  // The compare is one bit wider than the counter. That keeps the terminal
  // test exact for a tile of 2^BEAT_W-1 beats, and the counter never wraps.
  assign last_beat = (({1'b0, cnt_q} + {{BEAT_W{1'b0}}, 1'b1}) == {1'b0, beats_q});

  // Next-state and datapath. Operand and bias drives default to zero each
  // cycle, so any cycle without a handshake feeds zeros to the MPE.
  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    scale_d    = scale_q;
    bias_lat_d = bias_lat_q;
    a_first_d  = '0;
    a_rest_d   = '0;
    b_d        = '0;
    bias_d     = '0;
    in_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
    stall_d    = stall_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (tile_start && (tile_beats != '0)) begin
          beats_d    = tile_beats;
          mode_d     = tile_mode;
          scale_d    = tile_scale;
          bias_lat_d = tile_bias;
          cnt_d      = '0;
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
          stall_d    = '0;
`endif
          state_d    = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (handshake) begin
          a_first_d = s_a_first;
          a_rest_d  = s_a_rest;
          b_d       = s_b;
          // The bias is added once per tile, together with beat 0.
          if (cnt_q == '0) begin
            bias_d = bias_lat_q;
          end
          cnt_d = cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1};
          if (last_beat) begin
            state_d = ST_FLAG;
          end
        end
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
        if (!s_valid && (stall_q != 16'hFFFF)) begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end

      // The last beat is on the operand ports during this cycle. The
      // inputs-complete strobe follows on the next cycle.
      ST_FLAG: begin
        in_valid_d = 1'b1;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (mpe_out_valid) begin
          done_d  = 1'b1;
          state_d = ST_GAP;
        end
      end

      // One dead cycle while the MPE clears its accumulators.
      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and every output register clear asynchronously. A reset in
  // mid-tile therefore drops the tile with no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beats_q    <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      scale_q    <= '0;
      bias_lat_q <= '0;
      a_first_q  <= '0;
      a_rest_q   <= '0;
      b_q        <= '0;
      bias_q     <= '0;
      in_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      scale_q    <= scale_d;
      bias_lat_q <= bias_lat_d;
      a_first_q  <= a_first_d;
      a_rest_q   <= a_rest_d;
      b_q        <= b_d;
      bias_q     <= bias_d;
      in_valid_q <= in_valid_d;
      done_q     <= done_d;
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign tile_busy    = (state_q != ST_IDLE);
  assign tile_done    = done_q;
  assign mpe_mode     = mode_q;
  assign mpe_scale    = scale_q;
  assign mpe_a_first  = a_first_q;
  assign mpe_a_rest   = a_rest_q;
  assign mpe_b        = b_q;
  assign mpe_bias     = bias_q;
  assign mpe_in_valid = in_valid_q;
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
  assign stall_cnt    = stall_q;
`endif

endmodule

// File: tb/tb_mpe_tile_feeder.sv
// tb_mpe_tile_feeder: directed, table-driven bench for mpe_tile_feeder.
//
// Each vector row holds the inputs for one clock cycle and the outputs
// expected just after the following rising edge. Row fields:
//   data index -1 : all-zero operands expected
//   bias tag -1   : zero bias expected
//   stall -1      : stall count not checked on this row
// Hand-written sequences cover an asynchronous reset in mid-stream.

module tb_mpe_tile_feeder;

  localparam int DIMM1  = 2;
  localparam int DIMM2  = 1;
  localparam int DIMM3  = 64;
  localparam int BEAT_W = 8;
  localparam int AF_W   = DIMM3 * 8;
  localparam int AR_W   = DIMM3 * (DIMM1 - 1) * 4;
  localparam int B_W    = DIMM3 * DIMM2 * 4;
  localparam int SC_W   = DIMM1 * DIMM2 * 32;
  localparam int BI_W   = DIMM1 * DIMM2 * 16;
  localparam int NROWS  = 26;

  logic              clk;
  logic              rst_n;
  logic              tile_start;
  logic [BEAT_W-1:0] tile_beats;
  logic [1:0]        tile_mode;
  logic [SC_W-1:0]   tile_scale;
  logic [BI_W-1:0]   tile_bias;
  logic              tile_busy;
  logic              tile_done;
  logic              s_valid;
  logic              s_ready;
  logic [AF_W-1:0]   s_a_first;
  logic [AR_W-1:0]   s_a_rest;
  logic [B_W-1:0]    s_b;
  logic [1:0]        mpe_mode;
  logic [AF_W-1:0]   mpe_a_first;
  logic [AR_W-1:0]   mpe_a_rest;
  logic [B_W-1:0]    mpe_b;
  logic [SC_W-1:0]   mpe_scale;
  logic [BI_W-1:0]   mpe_bias;
  logic              mpe_in_valid;
  logic              mpe_out_valid;
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct {
    logic        start;
    logic [7:0]  beats;
    logic [1:0]  mode;
    int          tag;
    logic        valid;
    int          d_idx;
    logic        out_v;
    logic        e_busy;
    logic        e_ready;
    logic        e_done;
    logic        e_in_v;
    int          e_port;
    int          e_bias;
    logic [1:0]  e_mode;
    int          e_scale;
    int          e_stall;
  } vec_t;

  vec_t tbl [NROWS];

  mpe_tile_feeder #(
    .DIMM1(DIMM1), .DIMM2(DIMM2), .DIMM3(DIMM3), .BEAT_W(BEAT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tile_start   (tile_start),
    .tile_beats   (tile_beats),
    .tile_mode    (tile_mode),
    .tile_scale   (tile_scale),
    .tile_bias    (tile_bias),
    .tile_busy    (tile_busy),
    .tile_done    (tile_done),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_a_first    (s_a_first),
    .s_a_rest     (s_a_rest),
    .s_b          (s_b),
    .mpe_mode     (mpe_mode),
    .mpe_a_first  (mpe_a_first),
    .mpe_a_rest   (mpe_a_rest),
    .mpe_b        (mpe_b),
    .mpe_scale    (mpe_scale),
    .mpe_bias     (mpe_bias),
    .mpe_in_valid (mpe_in_valid),
    .mpe_out_valid(mpe_out_valid)
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Deterministic operand patterns per data index; index -1 means zero.
  function automatic logic [AF_W-1:0] a_first_of(input int i);
    logic [AF_W-1:0] r;
    r = '0;
    if (i >= 0) for (int k = 0; k < DIMM3; k++) r[k*8 +: 8] = 8'(i * 37 + k * 5 + 1);
    return r;
  endfunction

  function automatic logic [AR_W-1:0] a_rest_of(input int i);
    logic [AR_W-1:0] r;
    r = '0;
    if (i >= 0) for (int k = 0; k < AR_W / 4; k++) r[k*4 +: 4] = 4'(i * 3 + k + 2);
    return r;
  endfunction

  function automatic logic [B_W-1:0] b_of(input int i);
    logic [B_W-1:0] r;
    r = '0;
    if (i >= 0) for (int k = 0; k < B_W / 4; k++) r[k*4 +: 4] = 4'(i * 11 + k * 7 + 5);
    return r;
  endfunction

  function automatic logic [SC_W-1:0] scale_of(input int tag);
    if (tag <= 0) return '0;
    return {32'(tag * 1000 + 7), 32'(tag * 77 + 1)};
  endfunction

  function automatic logic [BI_W-1:0] bias_of(input int tag);
    if (tag <= 0) return '0;
    return {16'(tag * 273 + 3), 16'(tag * 13 + 15360)};
  endfunction

  function automatic vec_t mk(input int start, input int beats, input int mode, input int tag,
                              input int valid, input int d_idx, input int out_v,
                              input int e_busy, input int e_ready, input int e_done, input int e_in_v,
                              input int e_port, input int e_bias, input int e_mode, input int e_scale,
                              input int e_stall);
    vec_t v;
    v.start   = 1'(start);
    v.beats   = 8'(beats);
    v.mode    = 2'(mode);
    v.tag     = tag;
    v.valid   = 1'(valid);
    v.d_idx   = d_idx;
    v.out_v   = 1'(out_v);
    v.e_busy  = 1'(e_busy);
    v.e_ready = 1'(e_ready);
    v.e_done  = 1'(e_done);
    v.e_in_v  = 1'(e_in_v);
    v.e_port  = e_port;
    v.e_bias  = e_bias;
    v.e_mode  = 2'(e_mode);
    v.e_scale = e_scale;
    v.e_stall = e_stall;
    return v;
  endfunction

  task automatic cmp_field(input string label, input logic [AF_W-1:0] got, input logic [AF_W-1:0] want);
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h want %0h", label, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    tile_start    = v.start;
    tile_beats    = v.beats;
    tile_mode     = v.mode;
    tile_scale    = scale_of(v.tag);
    tile_bias     = bias_of(v.tag);
    s_valid       = v.valid;
    s_a_first     = a_first_of(v.d_idx);
    s_a_rest      = a_rest_of(v.d_idx);
    s_b           = b_of(v.d_idx);
    mpe_out_valid = v.out_v;
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    vectors_applied++;
    cmp_field({name, " busy"},     AF_W'(tile_busy),    AF_W'(v.e_busy));
    cmp_field({name, " ready"},    AF_W'(s_ready),      AF_W'(v.e_ready));
    cmp_field({name, " done"},     AF_W'(tile_done),    AF_W'(v.e_done));
    cmp_field({name, " in_valid"}, AF_W'(mpe_in_valid), AF_W'(v.e_in_v));
    cmp_field({name, " mode"},     AF_W'(mpe_mode),     AF_W'(v.e_mode));
    cmp_field({name, " scale"},    AF_W'(mpe_scale),    AF_W'(scale_of(v.e_scale)));
    cmp_field({name, " bias"},     AF_W'(mpe_bias),     AF_W'(bias_of(v.e_bias)));
    cmp_field({name, " a_first"},  mpe_a_first,         a_first_of(v.e_port));
    cmp_field({name, " a_rest"},   AF_W'(mpe_a_rest),   AF_W'(a_rest_of(v.e_port)));
    cmp_field({name, " b"},        AF_W'(mpe_b),        AF_W'(b_of(v.e_port)));
`ifdef MPE_TILE_FEEDER_STALL_CNT_EN
    if (v.e_stall >= 0) cmp_field({name, " stall_cnt"}, AF_W'(stall_cnt), AF_W'(v.e_stall));
`endif
  endtask

  task automatic run_row(input vec_t v, input string name);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v, name);
  endtask

  initial begin
    vec_t zero_v;

    // Row layout: start beats mode tag | valid d_idx out_v |
    //   busy ready done in_valid | port bias mode scale stall
    // Tile 1: 4 beats, back-to-back; stray result strobes in STREAM and FLAG.
    tbl[0]  = mk(1,4,1,1, 0,99,0, 1,1,0,0, -1,-1,1,1, 0);
    tbl[1]  = mk(0,0,0,9, 1, 0,0, 1,1,0,0,  0, 1,1,1, 0);
    tbl[2]  = mk(0,0,0,9, 1, 1,1, 1,1,0,0,  1,-1,1,1,-1);
    tbl[3]  = mk(0,0,0,9, 1, 2,0, 1,1,0,0,  2,-1,1,1,-1);
    tbl[4]  = mk(0,0,0,9, 1, 3,0, 1,0,0,0,  3,-1,1,1,-1);
    tbl[5]  = mk(0,0,0,9, 1,99,1, 1,0,0,1, -1,-1,1,1,-1);
    tbl[6]  = mk(0,0,0,9, 0,99,0, 1,0,0,0, -1,-1,1,1,-1);
    tbl[7]  = mk(0,0,0,9, 0,99,1, 1,0,1,0, -1,-1,1,1,-1);
    tbl[8]  = mk(0,0,0,9, 0,99,0, 0,0,0,0, -1,-1,1,1, 0);
    // Tile 2: 3 beats with two bubbles between beats 1 and 2.
    tbl[9]  = mk(1,3,2,2, 0,99,0, 1,1,0,0, -1,-1,2,2, 0);
    tbl[10] = mk(0,0,0,9, 1,10,0, 1,1,0,0, 10, 2,2,2,-1);
    tbl[11] = mk(0,0,0,9, 1,11,0, 1,1,0,0, 11,-1,2,2,-1);
    tbl[12] = mk(0,0,0,9, 0,99,0, 1,1,0,0, -1,-1,2,2, 1);
    tbl[13] = mk(0,0,0,9, 0,99,0, 1,1,0,0, -1,-1,2,2, 2);
    tbl[14] = mk(0,0,0,9, 1,12,0, 1,0,0,0, 12,-1,2,2, 2);
    tbl[15] = mk(0,0,0,9, 0,99,0, 1,0,0,1, -1,-1,2,2,-1);
    tbl[16] = mk(0,0,0,9, 0,99,1, 1,0,1,0, -1,-1,2,2,-1);
    tbl[17] = mk(0,0,0,9, 0,99,0, 0,0,0,0, -1,-1,2,2, 2);
    // Tile 3: single beat; a start strobe arrives during WAIT.
    tbl[18] = mk(1,1,3,3, 0,99,0, 1,1,0,0, -1,-1,3,3, 0);
    tbl[19] = mk(0,0,0,9, 1,20,0, 1,0,0,0, 20, 3,3,3,-1);
    tbl[20] = mk(0,0,0,9, 0,99,0, 1,0,0,1, -1,-1,3,3,-1);
    tbl[21] = mk(1,5,0,5, 1,99,0, 1,0,0,0, -1,-1,3,3,-1);
    tbl[22] = mk(0,0,0,9, 0,99,1, 1,0,1,0, -1,-1,3,3,-1);
    tbl[23] = mk(0,0,0,9, 0,99,0, 0,0,0,0, -1,-1,3,3,-1);
    // Zero-beat start is ignored; mode/scale stay from tile 3.
    tbl[24] = mk(1,0,0,4, 1,99,0, 0,0,0,0, -1,-1,3,3,-1);
    tbl[25] = mk(0,0,0,9, 1,99,0, 0,0,0,0, -1,-1,3,3,-1);

    zero_v = mk(0,0,0,0, 0,-1,0, 0,0,0,0, -1,-1,0,0, 0);

    rst_n         = 1'b0;
    tile_start    = 1'b0;
    tile_beats    = '0;
    tile_mode     = '0;
    tile_scale    = '0;
    tile_bias     = '0;
    s_valid       = 1'b0;
    s_a_first     = '0;
    s_a_rest      = '0;
    s_b           = '0;
    mpe_out_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput(zero_v, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset after 2 of 4 beats, between clock edges.
    run_row(mk(1,4,1,6, 0,99,0, 1,1,0,0, -1,-1,1,6, 0), "rst_start");
    run_row(mk(0,0,0,9, 1,30,0, 1,1,0,0, 30, 6,1,6,-1), "rst_beat0");
    run_row(mk(0,0,0,9, 1,31,0, 1,1,0,0, 31,-1,1,6,-1), "rst_beat1");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(zero_v, "rst_async");
    @(posedge clk);
    #1;
    checkOutput(zero_v, "rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    run_row(mk(0,0,0,9, 0,99,0, 0,0,0,0, -1,-1,0,0, 0), "post_idle");
    // Fresh 2-beat tile after reset completes normally.
    run_row(mk(1,2,2,7, 0,99,0, 1,1,0,0, -1,-1,2,7, 0), "post_start");
    run_row(mk(0,0,0,9, 1,40,0, 1,1,0,0, 40, 7,2,7,-1), "post_beat0");
    run_row(mk(0,0,0,9, 1,41,0, 1,0,0,0, 41,-1,2,7,-1), "post_beat1");
    run_row(mk(0,0,0,9, 0,99,0, 1,0,0,1, -1,-1,2,7,-1), "post_inv");
    run_row(mk(0,0,0,9, 0,99,1, 1,0,1,0, -1,-1,2,7,-1), "post_done");
    run_row(mk(0,0,0,9, 0,99,0, 0,0,0,0, -1,-1,2,7, 0), "post_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
